mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single byte-wide `simple_memory` port between the accelerator's load/store engines: matrix tile loader, vector loader and result store. Requesters issue variable-length bursts of one byte per beat. The arbiter grants one requester per burst, holds the grant until that requester flags its last beat, and routes read data back with the memory's one-cycle read latency. It sits between the load/store engines and the memory instance, replacing each engine's private memory instance.

## Interface
- `NUM_REQ`, default 3: number of requesters, range 2..8.
- `ADDR_WIDTH`, default 24: memory address width.
- `DATA_WIDTH`, default 8: memory data width.
- `clk` in 1: clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `req` in NUM_REQ: per-requester beat request.
- `req_last` in NUM_REQ: the current beat is the final beat of the burst.
- `req_we` in NUM_REQ: beat is a write.
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed beat addresses; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata` in NUM_REQ*DATA_WIDTH: packed write data.
- `gnt` out NUM_REQ: one-hot grant, registered.
- `rvalid` out NUM_REQ: one-hot read-data valid.
- `rdata` out DATA_WIDTH: read data, shared by all requesters; qualified by `rvalid`.
- `mem_addr` out ADDR_WIDTH: to memory.
- `mem_we` out 1: to memory.
- `mem_din` out DATA_WIDTH: to memory.
- `mem_dout` in DATA_WIDTH: from memory; synchronous read, valid 1 cycle after the address.
- `busy` out 1: high in BURST.

## Operation
- States: IDLE, BURST.
- **IDLE:** if any `req` is high, pick a winner, set `gnt[w]`, store `w` in `owner`, and go to BURST. Otherwise stay in IDLE.
- **Selection:** round-robin starting from `rr_ptr`. The first requester at or after `rr_ptr` (mod NUM_REQ) with `req` high wins.
- **BURST:** a beat fires in any cycle where `req[owner]` is high.
  - `mem_addr`, `mem_we` and `mem_din` are a combinational mux of the owner's inputs.
  - `mem_we` is `req_we[owner] & req[owner]`.
- **Stalls:** if the owner drops `req` mid-burst without `req_last`, the grant is held and `mem_we` is 0. The burst never times out.
- **End of burst:** a fired beat with `req_last[owner]` ends the burst. Next cycle: `gnt` = 0, state = IDLE, `rr_ptr` = (owner+1) mod NUM_REQ.
- **Read return:** for a fired read beat in cycle N, `rvalid[owner]` is high in cycle N+1 and `rdata` = `mem_dout`. This still applies when the beat was the last one, with the grant already dropped.
- **Idle outputs:** outside BURST, `mem_addr` holds its last value, `mem_we` = 0 and `mem_din` = 0.
- **Ignored inputs:** requests from non-owners during BURST are ignored. `req_last` without `req` is ignored.
- **Single-beat burst:** a burst of one beat is legal (`req` and `req_last` high together).

## Timing
- **Reset values:** `gnt` = 0, `rvalid` = 0, `busy` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_din` = 0, `rr_ptr` = 0, state = IDLE.
- **Reset mid-burst:** the burst is abandoned and any pending `rvalid` is cleared.
- **Grant latency:** `req` rises in cycle N (arbiter in IDLE) → `gnt` high in cycle N+1. The first beat may fire in N+1.
- **Burst gap:** one mandatory IDLE cycle separates consecutive bursts. The last beat fires in cycle M → re-arbitration in M+1 → new `gnt` in M+2.
- **Throughput:** one beat per cycle within a burst.
- **Requester contract:** hold `req` and all beat fields stable until `gnt` is seen. Then present one beat per cycle.

## Configuration
- **`MEM_ARB_FIXED_PRIO_EN` defined:** fixed priority; the lowest index with `req` high wins. `rr_ptr` is not implemented, so requester 0 (matrix loader) always wins ties.
- **Undefined (default):** round-robin as described above.

## Structure
- Belongs in `accelerator_config_pkg`:
  - `NUM_MEM_REQ` = 3.
  - Requester IDs: `MEM_REQ_LOAD_M` = 0, `MEM_REQ_LOAD_V` = 1, `MEM_REQ_STORE` = 2.
  - The `arb_state_t` enum.
- Sub-module `mem_arb_picker`: combinational rotate-and-priority-encode.
  - Inputs: `req`, `rr_ptr`.
  - Outputs: one-hot winner and its index.
  - Also used in fixed-priority mode, with `rr_ptr` tied to 0.

## Test plan
- **Single requester:** req0 reads 4 beats at 0x000100..0x000103, last on beat 4 → `gnt[0]` from cycle 1, four `rvalid[0]` pulses carrying mem[0x100..0x103], `gnt` = 0 after the last beat, `busy` falls.
- **Contention, round-robin:** req0, req1 and req2 all request 2-beat bursts continuously → grant order 0, 1, 2, 0, with exactly one IDLE cycle between bursts. Under `MEM_ARB_FIXED_PRIO_EN` the order is 0, 0, 0.
- **Write then read:** req2 writes 0xA5 to 0x000200 (single beat) → req1 reads 0x000200 and gets `rvalid[1]` with `rdata` = 0xA5.
- **Stall mid-burst:** the owner drops `req` for 3 cycles between beats while req1 is pending → `gnt` held, no `mem_we`, no `rvalid` during the stall, and req1 is granted only after the owner's last beat.
- **Reset mid-burst:** `rst` asserted in the cycle after a read beat → next cycle all outputs at reset values, no `rvalid`, and the next arbitration starts from `rr_ptr` = 0.

Source files
------------

// File: rtl/accelerator_config_pkg.sv
// Accelerator-wide configuration shared by the load/store engines and the
// memory port arbiter: requester IDs and the arbiter state encoding.
package accelerator_config_pkg;

   localparam int unsigned NUM_MEM_REQ    = 3;

   localparam int unsigned MEM_REQ_LOAD_M = 0;
   localparam int unsigned MEM_REQ_LOAD_V = 1;
   localparam int unsigned MEM_REQ_STORE  = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Rotate-and-priority-encode: the first requester at or after rr_ptr
// (mod NUM_REQ) with req high wins. Tie rr_ptr to 0 for fixed priority.
module mem_arb_picker #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] win_onehot,
   output logic [IDX_W-1:0]   win_idx
);

   localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

   logic [2*NUM_REQ-1:0] dbl;
   logic                 found;
   logic [IDX_W:0]       sel;

   always_comb begin
      dbl   = {req, req} >> rr_ptr;
      found = 1'b0;
      sel   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!found && dbl[k]) begin
            found = 1'b1;
            sel   = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sel >= N_W) sel = sel - N_W;
         end
      end
      win_idx = sel[IDX_W-1:0];
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         win_onehot[j] = found && (sel == (IDX_W+1)'(j));
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Burst arbiter sharing one byte-wide simple_memory port among the load/store
// engines. Define MEM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module mem_port_arbiter
   import accelerator_config_pkg::*;
#(
   parameter int unsigned NUM_REQ    = NUM_MEM_REQ,
   parameter int unsigned ADDR_WIDTH = 24,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0]             req_last,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [NUM_REQ-1:0]             rvalid,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [ADDR_WIDTH-1:0]          mem_addr,
   output logic                           mem_we,
   output logic [DATA_WIDTH-1:0]          mem_din,
   input  logic [DATA_WIDTH-1:0]          mem_dout,
   output logic                           busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   arb_state_t              state_q, state_d;
   logic [NUM_REQ-1:0]      gnt_q, gnt_d;
   logic [NUM_REQ-1:0]      rvalid_q, rvalid_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [ADDR_WIDTH-1:0]   addr_hold_q, addr_hold_d;

   logic [IDX_W-1:0]        rr_ptr;
   logic [NUM_REQ-1:0]      win_onehot;
   logic [IDX_W-1:0]        win_idx;

   logic                    own_req;
   logic                    own_last;
   logic                    own_we;
   logic [ADDR_WIDTH-1:0]   own_addr;
   logic [DATA_WIDTH-1:0]   own_wdata;
   logic                    in_burst;
   logic                    fire;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   assign rr_ptr = rr_ptr_q;
`endif

   mem_arb_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req        (req),
      .rr_ptr     (rr_ptr),
      .win_onehot (win_onehot),
      .win_idx    (win_idx)
   );

   always_comb begin
      own_req   = 1'b0;
      own_last  = 1'b0;
      own_we    = 1'b0;
      own_addr  = '0;
      own_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IDX_W'(i)) begin
            own_req   = req[i];
            own_last  = req_last[i];
            own_we    = req_we[i];
            own_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            own_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign in_burst = (state_q == BURST);
   assign fire     = in_burst && own_req;

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      owner_d     = owner_q;
      rvalid_d    = '0;
      addr_hold_d = addr_hold_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_d    = rr_ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (|req) begin
               gnt_d   = win_onehot;
               owner_d = win_idx;
               state_d = BURST;
            end
         end
         BURST: begin
            addr_hold_d = own_addr;
            if (fire) begin
               // gnt_q is the owner's one-hot, reused as the read-return strobe
               if (!own_we) rvalid_d = gnt_q;
               if (own_last) begin
                  gnt_d   = '0;
                  state_d = IDLE;
`ifndef MEM_ARB_FIXED_PRIO_EN
                  rr_ptr_d = IDX_W'(wrap_inc(32'(owner_q), NUM_REQ));
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         rvalid_q    <= '0;
         owner_q     <= '0;
         addr_hold_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         rr_ptr_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         rvalid_q    <= rvalid_d;
         owner_q     <= owner_d;
         addr_hold_q <= addr_hold_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
         rr_ptr_q    <= rr_ptr_d;
`endif
      end
   end

   assign gnt      = gnt_q;
   assign rvalid   = rvalid_q;
   assign rdata    = mem_dout;
   assign busy     = in_burst;
   assign mem_addr = in_burst ? own_addr : addr_hold_q;
   assign mem_we   = fire && own_we;
   assign mem_din  = in_burst ? own_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural one-cycle-latency
// byte memory whose initial contents are addr[7:0] ^ 8'h3C.
module tb_mem_port_arbiter;

   localparam int unsigned NR = 3;
   localparam int unsigned AW = 24;
   localparam int unsigned DW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req, req_last, req_we;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     gnt, rvalid;
   logic [DW-1:0]     rdata;
   logic [AW-1:0]     mem_addr;
   logic              mem_we;
   logic [DW-1:0]     mem_din;
   logic [DW-1:0]     mem_dout;
   logic              busy;

   logic [7:0]        mem [0:4095];

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .NUM_REQ    (NR),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_last  (req_last),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .busy      (busy)
   );

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h3C;
      mem_dout = '0;
   end

   always @(posedge clk) begin
      mem_dout <= mem[mem_addr[11:0]];
      if (mem_we) mem[mem_addr[11:0]] <= mem_din;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int i, input logic r, input logic last, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i]              = r;
      req_last[i]         = last;
      req_we[i]           = we;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic clear_inputs();
      req = '0; req_last = '0; req_we = '0; req_addr = '0; req_wdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (gnt !== 3'b000) $display("FAIL reset_gnt got=%b exp=%b", gnt, 3'b000); else passes++;
      checks++; if (rvalid !== 3'b000) $display("FAIL reset_rvalid got=%b exp=%b", rvalid, 3'b000); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
      checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got=%b exp=0", mem_we); else passes++;
      checks++; if (mem_addr !== 24'h0) $display("FAIL reset_mem_addr got=%h exp=000000", mem_addr); else passes++;
      checks++; if (mem_din !== 8'h00) $display("FAIL reset_mem_din got=%h exp=00", mem_din); else passes++;
   endtask

   task automatic test_single();
      logic [7:0] exp_rd [4];
      exp_rd[0] = 8'h3C; exp_rd[1] = 8'h3D; exp_rd[2] = 8'h3E; exp_rd[3] = 8'h3F;
      do_reset();
      set_beat(0, 1'b1, 1'b0, 1'b0, 24'h000100, 8'h00);
      #1;
      checks++; if (gnt !== 3'b000) $display("FAIL single_gnt_c0 got=%b exp=%b", gnt, 3'b000); else passes++;
      tick();
      for (int b = 0; b < 4; b++) begin
         set_beat(0, 1'b1, (b == 3), 1'b0, 24'h000100 + 24'(b), 8'h00);
         #1;
         checks++; if (gnt !== 3'b001) $display("FAIL single_gnt_b%0d got=%b exp=%b", b, gnt, 3'b001); else passes++;
         checks++; if (mem_addr !== 24'h000100 + 24'(b)) $display("FAIL single_addr_b%0d got=%h exp=%h", b, mem_addr, 24'h000100 + 24'(b)); else passes++;
         if (b > 0) begin
            checks++; if (rvalid !== 3'b001 || rdata !== exp_rd[b-1]) $display("FAIL single_rd_b%0d got=%b/%h exp=001/%h", b, rvalid, rdata, exp_rd[b-1]); else passes++;
         end
         tick();
      end
      clear_inputs();
      #1;
      checks++; if (gnt !== 3'b000) $display("FAIL single_gnt_end got=%b exp=%b", gnt, 3'b000); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL single_busy_end got=%b exp=0", busy); else passes++;
      checks++; if (rvalid !== 3'b001 || rdata !== exp_rd[3]) $display("FAIL single_rd_last got=%b/%h exp=001/%h", rvalid, rdata, exp_rd[3]); else passes++;
      checks++; if (mem_addr !== 24'h000103 || mem_we !== 1'b0 || mem_din !== 8'h00) $display("FAIL single_idle_out got=%h/%b/%h exp=000103/0/00", mem_addr, mem_we, mem_din); else passes++;
      tick();
      checks++; if (rvalid !== 3'b000) $display("FAIL single_rvalid_clear got=%b exp=%b", rvalid, 3'b000); else passes++;
   endtask

   task automatic test_contention();
      logic [2:0] exp_gnt [11];
      int cnt [3];
      logic [2:0] fired;
      logic [2:0] lastv;
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_gnt = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001};
`else
      exp_gnt = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
`endif
      do_reset();
      for (int i = 0; i < 3; i++) cnt[i] = 0;
      for (int c = 0; c < 11; c++) begin
         for (int i = 0; i < 3; i++) begin
            lastv[i] = gnt[i] && (cnt[i] == 1);
            set_beat(i, 1'b1, lastv[i], 1'b0, 24'h000300 + 24'(i*16 + cnt[i]), 8'h00);
         end
         #1;
         checks++; if (gnt !== exp_gnt[c]) $display("FAIL rr_gnt_c%0d got=%b exp=%b", c, gnt, exp_gnt[c]); else passes++;
         checks++; if (busy !== (exp_gnt[c] != 3'b000)) $display("FAIL rr_busy_c%0d got=%b exp=%b", c, busy, exp_gnt[c] != 3'b000); else passes++;
         fired = gnt;
         tick();
         for (int i = 0; i < 3; i++)
            if (fired[i]) cnt[i] = lastv[i] ? 0 : cnt[i] + 1;
      end
   endtask

   task automatic test_write_read();
      do_reset();
      set_beat(2, 1'b1, 1'b1, 1'b1, 24'h000200, 8'hA5);
      tick();
      #1;
      checks++; if (gnt !== 3'b100) $display("FAIL wr_gnt got=%b exp=%b", gnt, 3'b100); else passes++;
      checks++; if (mem_we !== 1'b1 || mem_din !== 8'hA5 || mem_addr !== 24'h000200) $display("FAIL wr_beat got=%b/%h/%h exp=1/a5/000200", mem_we, mem_din, mem_addr); else passes++;
      tick();
      clear_inputs();
      set_beat(1, 1'b1, 1'b1, 1'b0, 24'h000200, 8'h00);
      #1;
      checks++; if (gnt !== 3'b000 || mem_we !== 1'b0 || mem_din !== 8'h00) $display("FAIL wr_gap got=%b/%b/%h exp=000/0/00", gnt, mem_we, mem_din); else passes++;
      checks++; if (rvalid !== 3'b000) $display("FAIL wr_no_rvalid got=%b exp=%b", rvalid, 3'b000); else passes++;
      tick();
      checks++; if (gnt !== 3'b010 || mem_we !== 1'b0) $display("FAIL rd_gnt got=%b/%b exp=010/0", gnt, mem_we); else passes++;
      tick();
      clear_inputs();
      #1;
      checks++; if (rvalid !== 3'b010 || rdata !== 8'hA5) $display("FAIL rd_data got=%b/%h exp=010/a5", rvalid, rdata); else passes++;
   endtask

   task automatic test_stall();
      do_reset();
      set_beat(0, 1'b1, 1'b0, 1'b1, 24'h000110, 8'h11);
      set_beat(1, 1'b1, 1'b1, 1'b0, 24'h000120, 8'h00);
      tick();
      #1;
      checks++; if (gnt !== 3'b001 || mem_we !== 1'b1) $display("FAIL stall_first got=%b/%b exp=001/1", gnt, mem_we); else passes++;
      tick();
      for (int s = 0; s < 3; s++) begin
         set_beat(0, 1'b0, 1'b0, 1'b1, 24'h000111, 8'h22);
         #1;
         checks++; if (gnt !== 3'b001 || mem_we !== 1'b0 || rvalid !== 3'b000) $display("FAIL stall_s%0d got=%b/%b/%b exp=001/0/000", s, gnt, mem_we, rvalid); else passes++;
         tick();
      end
      set_beat(0, 1'b1, 1'b1, 1'b0, 24'h000111, 8'h00);
      #1;
      checks++; if (gnt !== 3'b001 || mem_we !== 1'b0) $display("FAIL stall_last got=%b/%b exp=001/0", gnt, mem_we); else passes++;
      tick();
      set_beat(0, 1'b0, 1'b0, 1'b0, 24'h0, 8'h00);
      #1;
      checks++; if (gnt !== 3'b000 || busy !== 1'b0) $display("FAIL stall_end got=%b/%b exp=000/0", gnt, busy); else passes++;
      checks++; if (rvalid !== 3'b001 || rdata !== 8'h2D) $display("FAIL stall_rd got=%b/%h exp=001/2d", rvalid, rdata); else passes++;
      tick();
      checks++; if (gnt !== 3'b010) $display("FAIL stall_next_gnt got=%b exp=%b", gnt, 3'b010); else passes++;
   endtask

   task automatic test_reset_mid_burst();
      logic [2:0] exp_c3;
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_c3 = 3'b001;
`else
      exp_c3 = 3'b100;
`endif
      do_reset();
      set_beat(1, 1'b1, 1'b1, 1'b0, 24'h000130, 8'h00);
      tick();
      tick();
      clear_inputs();
      set_beat(0, 1'b1, 1'b0, 1'b0, 24'h000140, 8'h00);
      set_beat(2, 1'b1, 1'b0, 1'b0, 24'h000150, 8'h00);
      tick();
      #1;
      checks++; if (gnt !== exp_c3) $display("FAIL rstmid_gnt got=%b exp=%b", gnt, exp_c3); else passes++;
      tick();
      rst = 1'b1;
      #1;
      checks++; if (rvalid !== exp_c3) $display("FAIL rstmid_pending got=%b exp=%b", rvalid, exp_c3); else passes++;
      tick();
      rst = 1'b0;
      #1;
      checks++; if (gnt !== 3'b000 || rvalid !== 3'b000 || busy !== 1'b0) $display("FAIL rstmid_clear got=%b/%b/%b exp=000/000/0", gnt, rvalid, busy); else passes++;
      checks++; if (mem_we !== 1'b0 || mem_addr !== 24'h0 || mem_din !== 8'h00) $display("FAIL rstmid_mem got=%b/%h/%h exp=0/000000/00", mem_we, mem_addr, mem_din); else passes++;
      tick();
      checks++; if (gnt !== 3'b001) $display("FAIL rstmid_rr got=%b exp=%b", gnt, 3'b001); else passes++;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single();
      test_contention();
      test_write_read();
      test_stall();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
